// File: rtl/iter_alu_if.sv
// Handshake and result bundle for the iterative ALU: the requester drives the
// start/opcode/operands, the ALU returns status and registered results.
interface iter_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       alu_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] alu_result_hi;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output start, alu_control, a, b,
    input  busy, done, alu_result, alu_result_hi, zero, div_by_zero
  );

  modport slave (
    input  start, alu_control, a, b,
    output busy, done, alu_result, alu_result_hi, zero, div_by_zero
  );
endinterface

// File: rtl/iter_alu.sv
// MIPS-style ALU: single-cycle logic/arith/shift ops, plus HI/LO multiply,
// multiply-accumulate and divide iterated one bit per cycle.
module iter_alu #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  iter_alu_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR,
    OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_ROTR,
    OP_MULT = 5'b10000, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MSUB,
    OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO
  } op_e;

  state_e             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [4:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Operand decode at acceptance: signed ops iterate on magnitudes.
  logic               signed_op, is_mul, is_div;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   alu_out;

  always_comb begin
    signed_op = (bus.alu_control == OP_MULT) || (bus.alu_control == OP_MADD) ||
                (bus.alu_control == OP_MSUB) || (bus.alu_control == OP_DIV);
    is_mul    = (bus.alu_control == OP_MULT) || (bus.alu_control == OP_MULTU) ||
                (bus.alu_control == OP_MADD) || (bus.alu_control == OP_MSUB);
    is_div    = (bus.alu_control == OP_DIV)  || (bus.alu_control == OP_DIVU);
    a_neg     = signed_op & bus.a[WIDTH-1];
    b_neg     = signed_op & bus.b[WIDTH-1];
    abs_a     = a_neg ? -bus.a : bus.a;
    abs_b     = b_neg ? -bus.b : bus.b;
    sh        = bus.b[SHW-1:0];
  end

  always_comb begin
    alu_out = '0;
    case (bus.alu_control)
      OP_ADD:  alu_out = bus.a + bus.b;
      OP_SUB:  alu_out = bus.a - bus.b;
      OP_AND:  alu_out = bus.a & bus.b;
      OP_OR:   alu_out = bus.a | bus.b;
      OP_NOR:  alu_out = ~(bus.a | bus.b);
      OP_XOR:  alu_out = bus.a ^ bus.b;
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      OP_SLL:  alu_out = bus.a << sh;
      OP_SRL:  alu_out = bus.a >> sh;
      OP_SRA:  alu_out = $signed(bus.a) >>> sh;
      OP_ROTR: alu_out = WIDTH'({bus.a, bus.a} >> sh);
      OP_MFHI: alu_out = hi_q;
      OP_MFLO: alu_out = lo_q;
      default: alu_out = '0;
    endcase
  end

  // One shift-add step: acc = {partial sum, remaining multiplier bits}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, prod, mul_final;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    prod     = neg_q ? -mul_next : mul_next;
    case (op_q)
      OP_MADD: mul_final = {hi_q, lo_q} + prod;
      OP_MSUB: mul_final = {hi_q, lo_q} - prod;
      default: mul_final = prod;
    endcase
  end

  // One restoring step: acc = {partial remainder, dividend/quotient bits}.
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem, quo_mag, rem_mag;
  logic [2*WIDTH-1:0] div_next, div_final;

  always_comb begin
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_rem   = div_shift[WIDTH-1:0] - opnd_q;
    div_next  = {div_ge ? div_rem : div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
    quo_mag   = div_next[WIDTH-1:0];
    rem_mag   = div_next[2*WIDTH-1:WIDTH];
    div_final = {rem_neg_q ? -rem_mag : rem_mag, neg_q ? -quo_mag : quo_mag};
  end

  always_comb begin
    // NOTE: every _d takes its _q value first, so no path through the case infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    res_d     = res_q;
    res_hi_d  = res_hi_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d      = bus.alu_control;
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          if (is_mul) begin
            state_d = S_MUL;
            cnt_d   = '1;
            acc_d   = {{WIDTH{1'b0}}, abs_b};
            opnd_d  = abs_a;
          end else if (is_div && (bus.b != '0)) begin
            state_d = S_DIV;
            cnt_d   = '1;
            acc_d   = {{WIDTH{1'b0}}, abs_a};
            opnd_d  = abs_b;
          end else begin
            // Divide by zero lands here too: reports LO/HI untouched.
            done_d   = 1'b1;
            dbz_d    = is_div;
            res_d    = alu_out;
            res_hi_d = hi_q;
            case (bus.alu_control)
              OP_MTHI: begin
                hi_d     = bus.a;
                res_d    = lo_q;
                res_hi_d = bus.a;
              end
              OP_MTLO: begin
                lo_d  = bus.a;
                res_d = bus.a;
              end
              OP_DIV, OP_DIVU: res_d = lo_q;
              default: ;
            endcase
          end
        end
      end

      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          dbz_d    = 1'b0;
          hi_d     = mul_final[2*WIDTH-1:WIDTH];
          lo_d     = mul_final[WIDTH-1:0];
          res_d    = mul_final[WIDTH-1:0];
          res_hi_d = mul_final[2*WIDTH-1:WIDTH];
        end
      end

      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          dbz_d    = 1'b0;
          hi_d     = div_final[2*WIDTH-1:WIDTH];
          lo_d     = div_final[WIDTH-1:0];
          res_d    = div_final[WIDTH-1:0];
          res_hi_d = div_final[2*WIDTH-1:WIDTH];
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      res_q     <= '0;
      res_hi_q  <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      res_q     <= res_d;
      res_hi_q  <= res_hi_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = done_q;
  assign bus.alu_result    = res_q;
  assign bus.alu_result_hi = res_hi_q;
  assign bus.zero          = (res_q == '0);
  assign bus.div_by_zero   = dbz_q;
endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: an ordered vector table (HI/LO carry between
// rows) plus hand-written reset-abort and back-to-back sequences.
module tb_iter_alu;
  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, AND_ = 5'b00010, OR_ = 5'b00011,
                         NOR_ = 5'b00100, XOR_ = 5'b00101, SLT = 5'b00110, SLTU = 5'b00111,
                         SLL = 5'b01000, SRL = 5'b01001, SRA = 5'b01010, ROTR = 5'b01011,
                         MULT = 5'b10000, MULTU = 5'b10001, DIV = 5'b10010, DIVU = 5'b10011,
                         MADD = 5'b10100, MSUB = 5'b10101, MTHI = 5'b10110, MTLO = 5'b10111,
                         MFHI = 5'b11000, MFLO = 5'b11001, BAD = 5'b11111;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  iter_alu_if #(.WIDTH(32)) bus ();
  iter_alu #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start       = st;
    bus.alu_control = op;
    bus.a           = a;
    bus.b           = b;
  endtask

  task automatic run_op(input vec_t v);
    int   lat;
    int   busy_bad;
    logic exp_busy;
    exp_busy = (v.lat > 1);
    @(negedge clk);
    drive(1'b1, v.op, v.a, v.b);
    @(negedge clk);
    drive(1'b0, 5'($urandom), $urandom, $urandom);
    lat      = 1;
    busy_bad = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy !== exp_busy) busy_bad++;
      @(negedge clk);
      lat++;
    end
    check({v.name, ".latency"}, 64'(lat), 64'(v.lat));
    check({v.name, ".busy_during"}, 64'(busy_bad), 64'd0);
    check({v.name, ".busy_at_done"}, 64'(bus.busy), 64'd0);
    check({v.name, ".result"}, 64'(bus.alu_result), 64'(v.lo));
    check({v.name, ".result_hi"}, 64'(bus.alu_result_hi), 64'(v.hi));
    check({v.name, ".zero"}, 64'(bus.zero), 64'(v.lo == 32'd0));
    check({v.name, ".div_by_zero"}, 64'(bus.div_by_zero), 64'(v.dbz));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_bad;
    int done_seen;

    // name, op, a, b, expected LO/result, expected HI, div_by_zero, latency
    vecs.push_back('{"add_wrap",   ADD,   32'd1,        32'hFFFFFFFF, 32'h00000000, 32'h0,        1'b0, 1});
    vecs.push_back('{"sub_neg",    SUB,   32'd5,        32'd7,        32'hFFFFFFFE, 32'h0,        1'b0, 1});
    vecs.push_back('{"and",        AND_,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0,        1'b0, 1});
    vecs.push_back('{"or",         OR_,   32'hF0000000, 32'h0000000F, 32'hF000000F, 32'h0,        1'b0, 1});
    vecs.push_back('{"nor",        NOR_,  32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,        1'b0, 1});
    vecs.push_back('{"xor",        XOR_,  32'hAAAAAAAA, 32'hFFFF0000, 32'h5555AAAA, 32'h0,        1'b0, 1});
    vecs.push_back('{"slt",        SLT,   32'hFFFFFFFF, 32'd1,        32'h00000001, 32'h0,        1'b0, 1});
    vecs.push_back('{"sltu",       SLTU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'h0,        1'b0, 1});
    vecs.push_back('{"sll_amt",    SLL,   32'h00000001, 32'h00000024, 32'h00000010, 32'h0,        1'b0, 1});
    vecs.push_back('{"sll_31",     SLL,   32'h00000001, 32'd31,       32'h80000000, 32'h0,        1'b0, 1});
    vecs.push_back('{"srl",        SRL,   32'h80000000, 32'd4,        32'h08000000, 32'h0,        1'b0, 1});
    vecs.push_back('{"sra",        SRA,   32'h80000000, 32'd4,        32'hF8000000, 32'h0,        1'b0, 1});
    vecs.push_back('{"rotr8",      ROTR,  32'h12345678, 32'd8,        32'h78123456, 32'h0,        1'b0, 1});
    vecs.push_back('{"rotr0",      ROTR,  32'h12345678, 32'd32,       32'h12345678, 32'h0,        1'b0, 1});
    vecs.push_back('{"mult_neg",   MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0, 33});
    vecs.push_back('{"multu_max",  MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33});
    vecs.push_back('{"mfhi",       MFHI,  32'h0,        32'h0,        32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 1});
    vecs.push_back('{"mflo",       MFLO,  32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFE, 1'b0, 1});
    vecs.push_back('{"unlisted",   BAD,   32'h1234,     32'h5678,     32'h00000000, 32'hFFFFFFFE, 1'b0, 1});
    vecs.push_back('{"divu_7_2",   DIVU,  32'd7,        32'd2,        32'h00000003, 32'h00000001, 1'b0, 33});
    vecs.push_back('{"div_m7_2",   DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33});
    vecs.push_back('{"div_minm1",  DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 33});
    vecs.push_back('{"div_7_m2",   DIV,   32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 33});
    vecs.push_back('{"mtlo_5",     MTLO,  32'd5,        32'h0,        32'h00000005, 32'h00000001, 1'b0, 1});
    vecs.push_back('{"div_by0",    DIV,   32'd9,        32'h0,        32'h00000005, 32'h00000001, 1'b1, 1});
    vecs.push_back('{"mflo_clr",   MFLO,  32'h0,        32'h0,        32'h00000005, 32'h00000001, 1'b0, 1});
    vecs.push_back('{"mthi_0",     MTHI,  32'h0,        32'h0,        32'h00000005, 32'h00000000, 1'b0, 1});
    vecs.push_back('{"mtlo_ff",    MTLO,  32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 32'h00000000, 1'b0, 1});
    vecs.push_back('{"madd_1_1",   MADD,  32'd1,        32'd1,        32'h00000000, 32'h00000001, 1'b0, 33});
    vecs.push_back('{"msub_1_1",   MSUB,  32'd1,        32'd1,        32'hFFFFFFFF, 32'h00000000, 1'b0, 33});
    vecs.push_back('{"msub_m3_4",  MSUB,  32'hFFFFFFFD, 32'd4,        32'h0000000B, 32'h00000001, 1'b0, 33});
    vecs.push_back('{"add_hi",     ADD,   32'd2,        32'd3,        32'h00000005, 32'h00000001, 1'b0, 1});
    vecs.push_back('{"divu_max16", DIVU,  32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, 32'h0000000F, 1'b0, 33});
    vecs.push_back('{"div_m8_m3",  DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'h00000002, 32'hFFFFFFFE, 1'b0, 33});
    vecs.push_back('{"divu_by0",   DIVU,  32'd1,        32'h0,        32'h00000002, 32'hFFFFFFFE, 1'b1, 1});

    drive(1'b0, ADD, 32'h0, 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset.busy", 64'(bus.busy), 64'd0);
    check("reset.done", 64'(bus.done), 64'd0);
    check("reset.result", 64'(bus.alu_result), 64'd0);
    check("reset.result_hi", 64'(bus.alu_result_hi), 64'd0);
    check("reset.zero", 64'(bus.zero), 64'd1);
    check("reset.div_by_zero", 64'(bus.div_by_zero), 64'd0);
    reset = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // MULTU aborted by reset; a SUB start while busy must be ignored.
    @(negedge clk);
    drive(1'b1, MULTU, 32'd3, 32'd5);
    busy_bad  = 0;
    done_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.done !== 1'b0) done_seen++;
      if (k == 1) drive(1'b0, ADD, $urandom, $urandom);
      if (k == 5) begin
        check("abort.hold_result", 64'(bus.alu_result), 64'h2);
        check("abort.hold_dbz", 64'(bus.div_by_zero), 64'd1);
        drive(1'b1, SUB, 32'd9, 32'd4);
      end
      if (k == 6) drive(1'b0, ADD, 32'h0, 32'h0);
      if (k == 10) begin
        reset = 1'b1;
        drive(1'b1, ADD, 32'd1, 32'd1);
      end
    end
    check("abort.busy_run", 64'(busy_bad), 64'd0);
    check("abort.no_done", 64'(done_seen), 64'd0);
    @(negedge clk);
    check("abort.busy", 64'(bus.busy), 64'd0);
    check("abort.done", 64'(bus.done), 64'd0);
    check("abort.result", 64'(bus.alu_result), 64'd0);
    check("abort.result_hi", 64'(bus.alu_result_hi), 64'd0);
    check("abort.zero", 64'(bus.zero), 64'd1);
    check("abort.div_by_zero", 64'(bus.div_by_zero), 64'd0);
    reset = 1'b0;
    drive(1'b1, MFHI, 32'h0, 32'h0);
    @(negedge clk);
    check("post_reset.done", 64'(bus.done), 64'd1);
    check("post_reset.hi_cleared", 64'(bus.alu_result), 64'd0);
    drive(1'b0, ADD, 32'h0, 32'h0);
    run_op('{"post_reset.mflo", MFLO, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1});

    // Start accepted in the Done cycle, then results hold while idle.
    @(negedge clk);
    drive(1'b1, ADD, 32'd1, 32'd2);
    @(negedge clk);
    check("b2b.first_done", 64'(bus.done), 64'd1);
    check("b2b.first_result", 64'(bus.alu_result), 64'd3);
    drive(1'b1, ADD, 32'd10, 32'd20);
    @(negedge clk);
    check("b2b.second_done", 64'(bus.done), 64'd1);
    check("b2b.second_result", 64'(bus.alu_result), 64'd30);
    drive(1'b0, SUB, 32'd7, 32'd7);
    @(negedge clk);
    check("b2b.pulse_end", 64'(bus.done), 64'd0);
    repeat (3) @(negedge clk);
    check("b2b.hold_result", 64'(bus.alu_result), 64'd30);
    check("b2b.hold_zero", 64'(bus.zero), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; SHALL be a power of two, at least 8.
REQ-002 Clk  input  1  the only clock; all state SHALL update on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request; sampled only while the block accepts (see REQ-011).
REQ-005 ALUControl  input  5  operation code, sampled with Start.
REQ-006 A, B  input  WIDTH each  operands, sampled with Start; B[log2(WIDTH)-1:0] is the shift/rotate amount.
REQ-007 Busy  output  1  iterative operation in progress.
REQ-008 Done  output  1  one-cycle pulse; results valid and new.
REQ-009 ALUResult, ALUResultHi  output  WIDTH each  registered low and high result.
REQ-010 Zero (ALUResult == 0) and DivByZero (last completed op was DIV/DIVU with B = 0)  output  1 each.

Function
REQ-011 Start SHALL be accepted when Busy = 0, including the Done cycle; Start while Busy = 1 SHALL be ignored.
REQ-012 FSM states SHALL be IDLE, MUL, DIV; no other states.
REQ-013 Single-cycle codes SHALL give Done at cycle n+1 for Start at cycle n, with Busy staying 0: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 NOR, 00101 XOR, 00110 SLT (signed), 00111 SLTU, 01000 SLL, 01001 SRL, 01010 SRA, 01011 ROTR.
REQ-014 For REQ-013 codes, ALUResult SHALL be the result and ALUResultHi SHALL be the current HI; ADD/SUB wrap modulo 2^WIDTH with no trap; SLT/SLTU give 1 or 0.
REQ-015 Internal HI and LO registers (WIDTH each) SHALL be updated only by codes 10000-10111.
REQ-016 10000 MULT (signed) and 10001 MULTU SHALL iterate in MUL state, one shift-add step per cycle: Busy = 1 at cycles n+1..n+WIDTH, Done at n+WIDTH+1; {HI,LO} = full 2*WIDTH product.
REQ-017 10100 MADD and 10101 MSUB SHALL use MUL timing; {HI,LO} +/-= signed A*B, modulo 2^(2*WIDTH).
REQ-018 10010 DIV (signed) and 10011 DIVU SHALL iterate in DIV state, one restoring step per cycle, with MUL timing; LO = quotient, HI = remainder.
REQ-019 Signed division SHALL truncate toward zero, with the remainder taking the dividend's sign; most-negative / -1 SHALL give LO = most-negative, HI = 0.
REQ-020 DIV/DIVU with B = 0 SHALL complete like a single-cycle op (Done at n+1, Busy 0), with DivByZero = 1 and HI/LO unchanged.
REQ-021 DivByZero SHALL be cleared by any other completion.
REQ-022 10110 MTHI (HI = A) and 10111 MTLO (LO = A) SHALL be single-cycle.
REQ-023 11000 MFHI (ALUResult = HI) and 11001 MFLO (ALUResult = LO) SHALL be single-cycle.
REQ-024 Unlisted codes SHALL be single-cycle, with ALUResult = 0 and state unchanged.
REQ-025 For codes 10000-10111, at Done ALUResult SHALL be the new LO and ALUResultHi the new HI.
REQ-026 ALUResult, ALUResultHi, Zero and DivByZero SHALL hold their values between Done pulses.
REQ-027 Operands SHALL be captured at acceptance; A/B changes while Busy SHALL have no effect.

Reset
REQ-028 Reset = 1 at a rising edge SHALL force IDLE.
REQ-029 Reset SHALL force Busy = 0, Done = 0, ALUResult = 0, ALUResultHi = 0, HI = 0, LO = 0, DivByZero = 0, and Zero = 1.
REQ-030 Reset SHALL take priority over Start.
REQ-031 Reset during MUL/DIV SHALL abort with no Done pulse; Start is accepted in the first cycle after Reset deasserts.

Verification (WIDTH = 32)
REQ-032 ADD, A = 1, B = 32'hFFFFFFFF -> Done at n+1, ALUResult = 0, Zero = 1, Busy never 1.
REQ-033 MULT, A = -2, B = 3 -> Busy for 32 cycles, Done at n+33, ALUResultHi = 32'hFFFFFFFF, ALUResult = 32'hFFFFFFFA.
REQ-034 DIVU 7/2 -> LO = 3, HI = 1; then DIV -7/2 -> LO = 32'hFFFFFFFD, HI = 32'hFFFFFFFF; then DIV 32'h80000000 / -1 -> LO = 32'h80000000, HI = 0.
REQ-035 DIV, B = 0, after MTLO A = 5 -> Done at n+1, DivByZero = 1, then MFLO returns 5 with DivByZero = 0.
REQ-036 MTHI 0, MTLO 32'hFFFFFFFF, then MADD A = 1, B = 1 -> HI = 1, LO = 0; then MSUB A = 1, B = 1 -> HI = 0, LO = 32'hFFFFFFFF.
REQ-037 MULTU started, SUB Start at n+5 (ignored), Reset at n+10 -> no Done, all outputs per REQ-029; back-to-back ADD Start in a Done cycle -> Done again one cycle later.
